// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU datapath among NREQ requesters.
// Optional BUSY watchdog is compiled in with `define ALU_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready to accept a request
// BUSY  | operation in flight on the datapath
// RESP  | one-cycle response to the issuing requester
module alu_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*4-1:0]   req_opcode,
   input  logic [NREQ*8-1:0]   req_a,
   input  logic [NREQ*8-1:0]   req_b,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [WIDTH-1:0]    rsp_result,
   output logic                rsp_error,
   output logic                dp_enable,
   output logic [3:0]          dp_opcode,
   output logic [7:0]          dp_a,
   output logic [7:0]          dp_b,
   input  logic                dp_done,
   input  logic [WIDTH-1:0]    dp_result
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     last_q, idx_q, grant_idx;
   logic              grant_found;
   logic [3:0]        op_q, sel_op;
   logic [7:0]        a_q, b_q, sel_a, sel_b;
   logic [WIDTH-1:0]  result_q;
   logic              error_q;
   logic              accept, op_valid, timeout_hit;
   int                cand;

   // Search starts one past the last winner and wraps.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(last_q) + 1 + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!grant_found && req_valid[cand[IW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[IW-1:0];
         end
      end
   end

   assign sel_op   = req_opcode[4*int'(grant_idx) +: 4];
   assign sel_a    = req_a[8*int'(grant_idx) +: 8];
   assign sel_b    = req_b[8*int'(grant_idx) +: 8];
   assign op_valid = (sel_op[3:2] == 2'b00);

`ifdef ALU_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] busy_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         busy_cnt_q <= '0;
      else if (accept)
         busy_cnt_q <= '0;
      else if (state_q == BUSY)
         busy_cnt_q <= busy_cnt_q + CW'(1);
   end

   assign timeout_hit = (state_q == BUSY) && (busy_cnt_q == CW'(TIMEOUT - 1));
`else
   // TIMEOUT only matters when the watchdog is built in.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // req_ready is gated by reset so it also reads zero while reset is held.
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_found && reset) begin
               req_ready[grant_idx] = 1'b1;
               accept               = 1'b1;
               state_d              = op_valid ? BUSY : RESP;
            end
         end
         BUSY: begin
            if (dp_done || timeout_hit) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q   <= IW'(NREQ - 1);
         idx_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         error_q  <= 1'b0;
      end else if (accept) begin
         last_q   <= grant_idx;
         idx_q    <= grant_idx;
         op_q     <= sel_op;
         a_q      <= sel_a;
         b_q      <= sel_b;
         result_q <= '0;
         error_q  <= !op_valid;
      end else if (state_q == BUSY) begin
         if (dp_done) begin
            result_q <= dp_result;
            error_q  <= 1'b0;
         end else if (timeout_hit) begin
            result_q <= '0;
            error_q  <= 1'b1;
         end
      end
   end

   assign dp_enable  = (state_q == BUSY);
   assign dp_opcode  = dp_enable ? op_q : 4'd0;
   assign dp_a       = dp_enable ? a_q : 8'd0;
   assign dp_b       = dp_enable ? b_q : 8'd0;
   assign rsp_result = (state_q == RESP) ? result_q : '0;
   assign rsp_error  = (state_q == RESP) && error_q;

   always_comb begin
      rsp_valid = '0;
      if (state_q == RESP) rsp_valid[idx_q] = 1'b1;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (NREQ=4, WIDTH=16, TIMEOUT=64).
// Watchdog scenarios are selected by `define ALU_ARB_TIMEOUT_EN, matching the RTL build.
module tb_alu_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [15:0] req_opcode;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  rsp_valid;
   logic [15:0] rsp_result;
   logic        rsp_error;
   logic        dp_enable;
   logic [3:0]  dp_opcode;
   logic [7:0]  dp_a;
   logic [7:0]  dp_b;
   logic        dp_done;
   logic [15:0] dp_result;

   int n_checks = 0;
   int n_fail   = 0;
   int rr_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

   alu_arbiter #(.NREQ(4), .WIDTH(16), .TIMEOUT(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opcode (req_opcode),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .rsp_error  (rsp_error),
      .dp_enable  (dp_enable),
      .dp_opcode  (dp_opcode),
      .dp_a       (dp_a),
      .dp_b       (dp_b),
      .dp_done    (dp_done),
      .dp_result  (dp_result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected end of test");
      $fatal(1, "time limit");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      req_valid[i]         = 1'b1;
      req_opcode[4*i +: 4] = op;
      req_a[8*i +: 8]      = a;
      req_b[8*i +: 8]      = b;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         req_valid  = 4'($urandom);
         req_opcode = 16'($urandom);
         req_a      = $urandom;
         req_b      = $urandom;
         dp_done    = 1'($urandom);
         dp_result  = 16'($urandom);
         #1;
         n_checks++;
         if ({req_ready, rsp_valid, rsp_result, rsp_error, dp_enable, dp_opcode, dp_a, dp_b} !== 54'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {req_ready, rsp_valid, rsp_result, rsp_error, dp_enable, dp_opcode, dp_a, dp_b});
         end
         step();
      end
      req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0;
      dp_done = 1'b0; dp_result = '0;
      reset = 1'b1;
      set_req(2, 4'd1, 8'h12, 8'h34);
      #1;
      n_checks++;
      if (req_ready !== 4'b0100) begin
         n_fail++; $display("FAIL first_ready: got %b expected 0100", req_ready);
      end
      step();
      req_valid = '0;
      n_checks++;
      if ({dp_enable, dp_opcode, dp_a, dp_b} !== {1'b1, 4'd1, 8'h12, 8'h34}) begin
         n_fail++; $display("FAIL first_dp: got en/op/a/b %h expected 1_1_12_34", {dp_enable, dp_opcode, dp_a, dp_b});
      end
      step();
      dp_done = 1'b1; dp_result = 16'h0046;
      step();
      dp_done = 1'b0;
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_error, dp_enable} !== {4'b0100, 16'h0046, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL first_rsp: got valid %b result %h err %b en %b expected 0100 0046 0 0", rsp_valid, rsp_result, rsp_error, dp_enable);
      end
      step();
   endtask

   task automatic test_round_robin();
      int g;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 4'(i), 8'(16*i + 1), 8'(16*i + 2));
      #1;
      for (int t = 0; t < 8; t++) begin
         g = rr_order[t];
         n_checks++;
         if (req_ready !== 4'(1 << g)) begin
            n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", t, req_ready, 4'(1 << g));
         end
         step();
         n_checks++;
         if ({req_ready, dp_opcode, dp_a, dp_b} !== {4'b0000, 4'(g), 8'(16*g + 1), 8'(16*g + 2)}) begin
            n_fail++; $display("FAIL rr_busy[%0d]: got ready/op/a/b %h expected requester %0d fields", t, {req_ready, dp_opcode, dp_a, dp_b}, g);
         end
         dp_done = 1'b1; dp_result = 16'(16'h0100 + t);
         step();
         dp_done = 1'b0;
         n_checks++;
         if ({rsp_valid, rsp_result, rsp_error} !== {4'(1 << g), 16'(16'h0100 + t), 1'b0}) begin
            n_fail++; $display("FAIL rr_rsp[%0d]: got valid %b result %h err %b expected %b %h 0", t, rsp_valid, rsp_result, rsp_error, 4'(1 << g), 16'(16'h0100 + t));
         end
         step();
      end
      req_valid = '0;
   endtask

   task automatic test_invalid_opcode();
      set_req(1, 4'hA, 8'h55, 8'h66);
      #1;
      n_checks++;
      if ({req_ready, dp_enable} !== {4'b0010, 1'b0}) begin
         n_fail++; $display("FAIL inv_ready: got ready %b en %b expected 0010 0", req_ready, dp_enable);
      end
      step();
      n_checks++;
      if ({dp_enable, rsp_valid, rsp_error, rsp_result} !== {1'b0, 4'b0010, 1'b1, 16'h0000}) begin
         n_fail++; $display("FAIL inv_rsp: got en %b valid %b err %b result %h expected 0 0010 1 0000", dp_enable, rsp_valid, rsp_error, rsp_result);
      end
      for (int i = 0; i < 4; i++) set_req(i, 4'd0, 8'h00, 8'h00);
      step();
      n_checks++;
      if ({req_ready, dp_enable, rsp_valid} !== {4'b0100, 1'b0, 4'b0000}) begin
         n_fail++; $display("FAIL inv_next_grant: got ready %b en %b valid %b expected 0100 0 0000", req_ready, dp_enable, rsp_valid);
      end
      req_valid = '0;
      #1;
   endtask

`ifdef ALU_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int bad;
      set_req(3, 4'd2, 8'hA0, 8'hB0);
      step();
      req_valid = '0;
      bad = 0;
      for (int c = 1; c < 64; c++) begin
         if (dp_enable !== 1'b1 || rsp_valid !== 4'b0000) bad++;
         step();
      end
      n_checks++;
      if ({bad, dp_enable} !== {32'd0, 1'b1}) begin
         n_fail++; $display("FAIL to_hold: got %0d bad cycles, en %b at cycle 64, expected 0 and 1", bad, dp_enable);
      end
      step();
      n_checks++;
      if ({rsp_valid, rsp_error, rsp_result, dp_enable} !== {4'b1000, 1'b1, 16'h0000, 1'b0}) begin
         n_fail++; $display("FAIL to_fire: got valid %b err %b result %h en %b expected 1000 1 0000 0", rsp_valid, rsp_error, rsp_result, dp_enable);
      end
      step();
      set_req(0, 4'd3, 8'h01, 8'h02);
      step();
      req_valid = '0;
      for (int c = 1; c < 64; c++) step();
      dp_done = 1'b1; dp_result = 16'hBEEF;
      step();
      dp_done = 1'b0;
      n_checks++;
      if ({rsp_valid, rsp_error, rsp_result} !== {4'b0001, 1'b0, 16'hBEEF}) begin
         n_fail++; $display("FAIL to_done_wins: got valid %b err %b result %h expected 0001 0 beef", rsp_valid, rsp_error, rsp_result);
      end
      step();
   endtask
`else
   task automatic test_busy_wait();
      int bad;
      set_req(3, 4'd2, 8'hA0, 8'hB0);
      step();
      req_valid = '0;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         if (dp_enable !== 1'b1 || rsp_valid !== 4'b0000) bad++;
         step();
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL busy_wait: got %0d cycles without dp_enable or with rsp_valid, expected 0", bad);
      end
      dp_done = 1'b1; dp_result = 16'h1234;
      step();
      dp_done = 1'b0;
      n_checks++;
      if ({rsp_valid, rsp_error, rsp_result} !== {4'b1000, 1'b0, 16'h1234}) begin
         n_fail++; $display("FAIL busy_wait_rsp: got valid %b err %b result %h expected 1000 0 1234", rsp_valid, rsp_error, rsp_result);
      end
      step();
   endtask
`endif

   task automatic test_reset_mid_busy();
      set_req(1, 4'd0, 8'h11, 8'h22);
      step();
      req_valid = '0;
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({dp_enable, rsp_valid, dp_a, dp_b} !== 21'd0) begin
         n_fail++; $display("FAIL mid_reset_outputs: got en %b valid %b a %h b %h expected all 0", dp_enable, rsp_valid, dp_a, dp_b);
      end
      dp_done = 1'b1;
      step();
      reset = 1'b1;
      dp_done = 1'b0;
      step();
      n_checks++;
      if ({rsp_valid, dp_enable} !== 5'd0) begin
         n_fail++; $display("FAIL mid_reset_no_rsp: got valid %b en %b expected 0000 0", rsp_valid, dp_enable);
      end
      for (int i = 0; i < 4; i++) set_req(i, 4'd1, 8'h00, 8'h00);
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL mid_reset_grant: got %b expected 0001", req_ready);
      end
      req_valid = '0;
      #1;
   endtask

   task automatic test_stray_done();
      dp_done = 1'b1;
      step();
      step();
      n_checks++;
      if ({rsp_valid, dp_enable} !== 5'd0) begin
         n_fail++; $display("FAIL stray_idle: got valid %b en %b expected 0000 0", rsp_valid, dp_enable);
      end
      dp_done = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 4'd1, 8'h00, 8'h00);
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL stray_grant: got %b expected 0001", req_ready);
      end
      step();
      req_valid = '0;
      dp_done = 1'b1; dp_result = 16'h0777;
      step();
      n_checks++;
      if ({rsp_valid, rsp_result} !== {4'b0001, 16'h0777}) begin
         n_fail++; $display("FAIL stray_rsp: got valid %b result %h expected 0001 0777", rsp_valid, rsp_result);
      end
      step();
      n_checks++;
      if ({rsp_valid, dp_enable, rsp_result} !== 21'd0) begin
         n_fail++; $display("FAIL stray_after_resp: got valid %b en %b result %h expected all 0", rsp_valid, dp_enable, rsp_result);
      end
      step();
      dp_done = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 4'd1, 8'h00, 8'h00);
      #1;
      n_checks++;
      if ({req_ready, rsp_valid} !== {4'b0010, 4'b0000}) begin
         n_fail++; $display("FAIL stray_next_grant: got ready %b valid %b expected 0010 0000", req_ready, rsp_valid);
      end
      req_valid = '0;
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = '0;
      req_opcode = '0;
      req_a      = '0;
      req_b      = '0;
      dp_done    = 1'b0;
      dp_result  = '0;
      #2;
      test_reset();
      test_round_robin();
      test_invalid_opcode();
`ifdef ALU_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_busy_wait();
`endif
      test_reset_mid_busy();
      test_stray_done();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter sharing one ALU datapath among NREQ requesters. Each requester presents an opcode and two 8-bit operands with a valid/ready handshake. The block issues one operation at a time to the datapath with the `enable`/`done` protocol and returns the result, or an error flag, to the requester that issued it. It sits between the instruction controllers (or other masters) and the single shared datapath instance.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 16: datapath result width.
- TIMEOUT, 64: maximum BUSY cycles before abort; only used when `ALU_ARB_TIMEOUT_EN` is defined.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept strobe; at most one bit high.
- req_opcode  input  NREQ*4  flat; requester i at [4i+3:4i].
- req_a, req_b  input  NREQ*8 each  flat operands; requester i at [8i+7:8i].
- rsp_valid  output  NREQ  one-cycle response pulse to the issuing requester.
- rsp_result  output  WIDTH  shared result bus; meaningful only while rsp_valid is nonzero.
- rsp_error  output  1  invalid opcode or timeout; qualified by rsp_valid.
- dp_enable  output  1  datapath enable.
- dp_opcode  output  4  datapath opcode.
- dp_a, dp_b  output  8 each  datapath operands.
- dp_done  input  1  datapath completion.
- dp_result  input  WIDTH  datapath result; sampled when dp_done is high.

## Operation
- States:
  - IDLE: ready to accept a request.
  - BUSY: an operation is in flight on the datapath.
  - RESP: the response is being returned.
- Grant rule: round-robin. The search starts at requester `(last+1) mod NREQ` and wraps. `last` resets to NREQ-1, so requester 0 wins first.
- IDLE behaviour:
  - `req_ready` is combinational: high only for the granted index, and only when that requester's `req_valid` is high.
  - A request is accepted when `req_valid[i] & req_ready[i]`.
  - On acceptance the block latches opcode, a, b and the index, and sets `last` to i.
- Opcode check at acceptance:
  - 0..3: valid; next state BUSY.
  - 4..15: invalid; next state RESP with `rsp_error`=1 and `rsp_result`=0. The datapath is never enabled.
- BUSY:
  - `dp_enable`=1.
  - `dp_opcode`, `dp_a`, `dp_b` hold the latched values and stay stable.
  - When `dp_done`=1: capture `dp_result`, go to RESP with error=0.
- RESP:
  - `rsp_valid[index]`=1 for exactly one cycle, with `rsp_result` and `rsp_error` valid in the same cycle.
  - Next state is IDLE.
- Requester rule: a requester holds `req_valid` and its fields stable until it sees `req_ready`. A request may be withdrawn before acceptance without effect.
- Data outputs outside BUSY: `dp_opcode`, `dp_a`, `dp_b` are 0.
- Result outputs outside RESP: `rsp_result` and `rsp_error` are 0.
- `dp_done` arriving while not in BUSY is ignored.
- Reset, including mid-operation, does all of the following immediately and asynchronously:
  - sets every output to 0 and state to IDLE;
  - sets `last` to NREQ-1;
  - drops the in-flight transaction with no response.

## Timing
- Accept edge to `dp_enable` high: 1 cycle.
- `dp_done` edge to `rsp_valid`: 1 cycle.
- Invalid opcode: `rsp_valid` in the cycle after acceptance.
- Minimum spacing between acceptances: 3 cycles for a valid op whose `dp_done` arrives in its first BUSY cycle; 2 cycles for an invalid op.
- `dp_enable` drops in the cycle after `dp_done` is sampled.
- Only one request is outstanding at any time. `req_ready` is all-zero outside IDLE.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - A counter clears on entering BUSY and increments each BUSY cycle.
  - If the counter reaches TIMEOUT with `dp_done` low, the block goes to RESP with `rsp_error`=1, `rsp_result`=0, and `dp_enable` drops.
  - If `dp_done` is high in the same cycle the timeout would fire, `dp_done` wins: normal response.
- `ALU_ARB_TIMEOUT_EN` not defined:
  - No counter; BUSY waits indefinitely for `dp_done`.
  - The TIMEOUT parameter is unused.

## Test plan
- Reset: hold reset low with random inputs. Required: all outputs 0. Release and drive requester 2 with opcode 1, a=0x12, b=0x34, `dp_done` one cycle after `dp_enable`, `dp_result`=0x0046. Required: `req_ready`=0b0100, then `dp_a`=0x12 and `dp_b`=0x34, then `rsp_valid`=0b0100 with `rsp_result`=0x0046 and error 0.
- Round-robin: all four `req_valid` held high for 8 transactions. Required: grant order 0,1,2,3,0,1,2,3; each `rsp_valid` matches its grant.
- Invalid opcode: requester 1 sends opcode 4'hA. Required: `dp_enable` stays 0, `rsp_valid`=0b0010 one cycle later, `rsp_error`=1, `rsp_result`=0. The next grant starts from requester 2.
- Timeout (macro defined, TIMEOUT=64): `dp_done` held low. Required: `rsp_error`=1 and `dp_enable`=0 after 64 BUSY cycles. Repeat with `dp_done` high in cycle 64: required normal result with error 0.
- Reset mid-BUSY: assert reset during BUSY. Required: immediate `dp_enable`=0, no `rsp_valid`, and after release requester 0 is granted first.
- Stray done: pulse `dp_done` in IDLE and in RESP. Required: no state change and no extra `rsp_valid`.
